// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares the single-ported, combinational-read font ROM
// between the VGA text fetcher (priority) and the CPU font read port.
// Each access runs through a fixed two-stage pipeline: grant/address
// register, then ROM read into the requester's data register.
// Optional feature macro: FONT_ARB_STARVE_GUARD_EN enables the CPU
// starvation guard. Without it, VGA has strict priority.
module font_rom_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("font_rom_arbiter: STARVE_MAX must be in 1..15");
  end

  logic force_cpu;
  logic vld_p1;
  logic src_p1;

`ifdef FONT_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  // Saturating increment of the starvation count.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= STARVE_LIM) return STARVE_LIM;
    return v + 4'd1;
  endfunction

  // Count consecutive denied CPU cycles; any grant or idle cycle clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (cpu_req && !cpu_gnt) begin
      starve_cnt <= sat_inc(starve_cnt);
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  assign force_cpu = (starve_cnt == STARVE_LIM);
`else
  assign force_cpu = 1'b0;
`endif

  // Arbitration: VGA wins unless the guard forces the CPU through.
  assign cpu_gnt = cpu_req & (~vga_req | force_cpu);
  assign vga_gnt = vga_req & ~cpu_gnt;

  // ---- Stage 1: latch the winner's address; it drives the ROM for S2 ----
  // Register ROM address and tag the in-flight access with its source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      vld_p1   <= 1'b0;
      src_p1   <= 1'b0;
    end else begin
      vld_p1 <= vga_gnt | cpu_gnt;
      if (cpu_gnt) begin
        rom_addr <= cpu_addr;
        src_p1   <= 1'b1;
      end else if (vga_gnt) begin
        rom_addr <= vga_addr;
        src_p1   <= 1'b0;
      end
    end
  end

  // ---- Stage 2: ROM output is settled; steer it to the owning requester ----
  // Capture ROM data for the requester; rdata holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      vga_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      vga_rvalid <= vld_p1 & ~src_p1;
      cpu_rvalid <= vld_p1 & src_p1;
      if (vld_p1 && !src_p1) vga_rdata <= rom_dout;
      if (vld_p1 && src_p1)  cpu_rdata <= rom_dout;
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Testbench for font_rom_arbiter: directed scenarios plus randomized
// request traffic, checked against a queue-based transaction model.
module tb_font_rom_arbiter;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vga_req = 1'b0;
  logic [ADDR_W-1:0] vga_addr = '0;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;

  logic [DATA_W-1:0] rom_mem [0:4095];

  always #5 clk = ~clk;

  assign rom_dout = rom_mem[rom_addr];

  font_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction model: each accepted request becomes one response due
  // exactly two cycles later carrying the ROM word at its address.
  typedef struct {
    int              due;
    bit              is_cpu;
    logic [DATA_W-1:0] data;
  } resp_t;

  resp_t             resp_q[$];
  int                cyc;
  int                m_starve;
  logic              m_vga_rvalid, m_cpu_rvalid;
  logic [DATA_W-1:0] m_vga_rdata, m_cpu_rdata;
  logic [ADDR_W-1:0] m_rom_addr, m_rom_addr_nxt;

  task automatic model_reset();
    resp_q.delete();
    m_starve       = 0;
    m_vga_rvalid   = 1'b0;
    m_cpu_rvalid   = 1'b0;
    m_vga_rdata    = '0;
    m_cpu_rdata    = '0;
    m_rom_addr     = '0;
    m_rom_addr_nxt = '0;
  endtask

  // One clock cycle: drive requests, check every output, advance the model.
  task automatic step(input logic vr, input logic [ADDR_W-1:0] va,
                      input logic cr, input logic [ADDR_W-1:0] ca,
                      output logic vg, output logic cg);
    bit    force_c;
    resp_t r;
    @(posedge clk); #1;
    vga_req = vr; vga_addr = va;
    cpu_req = cr; cpu_addr = ca;
    cyc++;
    m_rom_addr   = m_rom_addr_nxt;
    m_vga_rvalid = 1'b0;
    m_cpu_rvalid = 1'b0;
    while (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      r = resp_q.pop_front();
      if (r.is_cpu) begin m_cpu_rvalid = 1'b1; m_cpu_rdata = r.data; end
      else          begin m_vga_rvalid = 1'b1; m_vga_rdata = r.data; end
    end
`ifdef FONT_ARB_STARVE_GUARD_EN
    force_c = (m_starve >= STARVE_MAX);
`else
    force_c = 1'b0;
`endif
    cg = cr && (!vr || force_c);
    vg = vr && !cg;
    @(negedge clk);
    chk("vga_gnt",    32'(vga_gnt),    32'(vg));
    chk("cpu_gnt",    32'(cpu_gnt),    32'(cg));
    chk("vga_rvalid", 32'(vga_rvalid), 32'(m_vga_rvalid));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rvalid));
    chk("vga_rdata",  32'(vga_rdata),  32'(m_vga_rdata));
    chk("cpu_rdata",  32'(cpu_rdata),  32'(m_cpu_rdata));
    chk("rom_addr",   32'(rom_addr),   32'(m_rom_addr));
    if (cg) begin
      resp_q.push_back('{due: cyc + 2, is_cpu: 1'b1, data: rom_mem[ca]});
      m_rom_addr_nxt = ca;
    end else if (vg) begin
      resp_q.push_back('{due: cyc + 2, is_cpu: 1'b0, data: rom_mem[va]});
      m_rom_addr_nxt = va;
    end
    if (cr && !cg) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else           m_starve = 0;
  endtask

  task automatic idle(input int n);
    logic vg, cg;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, vg, cg);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vga_rvalid"}, 32'(vga_rvalid), 32'd0);
    chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    chk({tag, "_vga_rdata"},  32'(vga_rdata),  32'd0);
    chk({tag, "_cpu_rdata"},  32'(cpu_rdata),  32'd0);
    chk({tag, "_rom_addr"},   32'(rom_addr),   32'd0);
    chk({tag, "_vga_gnt"},    32'(vga_gnt),    32'd0);
    chk({tag, "_cpu_gnt"},    32'(cpu_gnt),    32'd0);
  endtask

  initial begin
    logic              vg, cg, vhold, chold, vr, cr, cgot;
    logic [ADDR_W-1:0] va, ca;
    int                first_cpu, exp_first;

    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
    cyc = 0;
    model_reset();

    // Power-on reset
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle CPU read
    step(1'b0, '0, 1'b1, 12'h041, vg, cg);
    idle(4);

    // Simultaneous requests: VGA first, CPU retries next cycle
    step(1'b1, 12'h208, 1'b1, 12'h30F, vg, cg);
    step(1'b0, '0,      1'b1, 12'h30F, vg, cg);
    idle(4);

    // VGA streaming 0x100..0x10F
    for (int i = 0; i < 16; i++) step(1'b1, 12'(12'h100 + i), 1'b0, '0, vg, cg);
    idle(4);

    // Sustained contention: measure when the CPU first gets through
    va = 12'h200; cgot = 1'b0; first_cpu = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, va, !cgot, 12'h3AA, vg, cg);
      if (cpu_gnt === 1'b1 && first_cpu < 0) first_cpu = i;
      if (cg) cgot = 1'b1;
      if (vg) va = va + 12'd1;
    end
`ifdef FONT_ARB_STARVE_GUARD_EN
    exp_first = STARVE_MAX;
`else
    exp_first = -1;
`endif
    chk("starve_first_cpu_gnt", 32'(first_cpu), 32'(exp_first));
    idle(4);

    // Reset during an in-flight VGA access
    step(1'b1, 12'h155, 1'b0, '0, vg, cg);
    @(posedge clk); #1;
    rst = 1'b1; vga_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc++;
    model_reset();
    idle(4);
    step(1'b1, 12'h0AB, 1'b0, '0, vg, cg);
    idle(3);

    // Randomized traffic obeying the hold-until-granted rule
    vhold = 1'b0; chold = 1'b0; va = '0; ca = '0; vr = 1'b0; cr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!vhold) begin
        vr = ($urandom_range(0, 3) != 0);
        va = 12'($urandom);
      end else if ($urandom_range(0, 31) == 0) begin
        vr = 1'b0;
      end
      if (!chold) begin
        cr = ($urandom_range(0, 1) != 0);
        ca = 12'($urandom);
      end else if ($urandom_range(0, 31) == 0) begin
        cr = 1'b0;
      end
      step(vr, va, cr, ca, vg, cg);
      vhold = vr && !vg;
      chold = cr && !cg;
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
